// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit:
// FSM encodings, counter width and register-match helper.
package hazard_unit_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic load_use;
    logic br_alu;
    logic br_load;
    logic br_mem;
  } hz_hit_t;

  // Register 0 is hardwired, so it never forwards or stalls.
  function automatic logic reg_match(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear,
// used for the stall and flush statistics.
module sat_counter
  import hazard_unit_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use and branch stalls,
// taken-branch flush, and saturating event counters.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IFID_RegisterRs,
  input  logic [4:0]       IFID_RegisterRt,
  input  logic             IFID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_RegDst,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_RegDst,
  input  logic             Cnt_Clear,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic             State_Hold
);

  hz_state_e state_q;
  hz_state_e state_d;
  hz_hit_t   hit;

  logic ex_rs;
  logic ex_rt;
  logic mem_rs;
  logic mem_rt;
  logic stall;
  logic flush;

  // Producer/consumer register matches.
  always_comb begin
    ex_rs  = reg_match(IDEX_RegDst, IFID_RegisterRs);
    ex_rt  = reg_match(IDEX_RegDst, IFID_RegisterRt);
    mem_rs = reg_match(EXMEM_RegDst, IFID_RegisterRs);
    mem_rt = reg_match(EXMEM_RegDst, IFID_RegisterRt);
  end

  // Hazard classes; branches compare both sources in ID.
  always_comb begin
    hit.load_use = IDEX_MemRead
                 & (ex_rs | (IFID_UsesRt & ex_rt));
    hit.br_alu   = ID_Branch & IDEX_RegWrite
                 & ~IDEX_MemRead & (ex_rs | ex_rt);
    hit.br_load  = ID_Branch & IDEX_MemRead
                 & (ex_rs | ex_rt);
    hit.br_mem   = ID_Branch & EXMEM_MemRead
                 & (mem_rs | mem_rt);
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch-on-load needs a second stall cycle via HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (hit.br_load) state_d = HOLD;
      HOLD: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Control outputs; stall overrides flush, reset stalls.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      RUN:  stall = |hit;
      HOLD: stall = 1'b1;
      default: stall = 1'b1;
    endcase
    flush       = ~stall & ID_Branch & ID_BranchTaken;
    PCWrite     = Rst & ~stall;
    IFIDWrite   = Rst & ~stall;
    IDEX_Bubble = ~Rst | stall;
    IFID_Flush  = Rst & flush;
    State_Hold  = (state_q == HOLD);
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .en_i  (stall),
    .clr_i (Cnt_Clear),
    .cnt_o (Stall_Cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .en_i  (flush),
    .clr_i (Cnt_Clear),
    .cnt_o (Flush_Cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: reference model of
// stall lengths plus directed hazard scenarios.
module tb_hazard_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [4:0]  Rs = '0;
  logic [4:0]  Rt = '0;
  logic        UsesRt = 1'b0;
  logic        Br = 1'b0;
  logic        Tk = 1'b0;
  logic        ExRd = 1'b0;
  logic        ExWr = 1'b0;
  logic [4:0]  ExDst = '0;
  logic        MemRd = 1'b0;
  logic [4:0]  MemDst = '0;
  logic        Clr = 1'b0;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEX_Bubble;
  logic        IFID_Flush;
  logic [15:0] Stall_Cnt;
  logic [15:0] Flush_Cnt;
  logic        State_Hold;

  hazard_unit dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .IFID_RegisterRs (Rs),
    .IFID_RegisterRt (Rt),
    .IFID_UsesRt     (UsesRt),
    .ID_Branch       (Br),
    .ID_BranchTaken  (Tk),
    .IDEX_MemRead    (ExRd),
    .IDEX_RegWrite   (ExWr),
    .IDEX_RegDst     (ExDst),
    .EXMEM_MemRead   (MemRd),
    .EXMEM_RegDst    (MemDst),
    .Cnt_Clear       (Clr),
    .PCWrite         (PCWrite),
    .IFIDWrite       (IFIDWrite),
    .IDEX_Bubble     (IDEX_Bubble),
    .IFID_Flush      (IFID_Flush),
    .Stall_Cnt       (Stall_Cnt),
    .Flush_Cnt       (Flush_Cnt),
    .State_Hold      (State_Hold)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  // Model: remaining forced stall cycles and counter values.
  int m_hold = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit dep(logic [4:0] d, logic [4:0] s);
    return (d != 0) && (d == s);
  endfunction

  // Cycles of stall demanded by the current ID/EX/MEM contents.
  function automatic int need_cycles();
    int n = 0;
    bit ex_any  = dep(ExDst, Rs) || dep(ExDst, Rt);
    bit mem_any = dep(MemDst, Rs) || dep(MemDst, Rt);
    if (ExRd && (dep(ExDst, Rs) || (UsesRt && dep(ExDst, Rt))))
      n = (n > 1) ? n : 1;
    if (Br && ExWr && !ExRd && ex_any)
      n = (n > 1) ? n : 1;
    if (Br && ExRd && ex_any)
      n = 2;
    if (Br && MemRd && mem_any)
      n = (n > 1) ? n : 1;
    return n;
  endfunction

  // Per-cycle comparison against the model, then model advance.
  always @(negedge Clk) begin
    int need;
    bit st;
    bit fl;
    if (chk_en) begin
      need = need_cycles();
      st   = (m_hold > 0) || (need > 0);
      fl   = !st && Br && Tk;
      chk("m_pcwrite", PCWrite, Rst && !st);
      chk("m_ifidwrite", IFIDWrite, Rst && !st);
      chk("m_bubble", IDEX_Bubble, !Rst || st);
      chk("m_flush", IFID_Flush, Rst && fl);
      chk("m_hold", State_Hold, m_hold > 0);
      chk("m_stall_cnt", Stall_Cnt, m_sc);
      chk("m_flush_cnt", Flush_Cnt, m_fc);
      if (!Rst) begin
        m_hold = 0;
        m_sc   = 0;
        m_fc   = 0;
      end else begin
        if (Clr) begin
          m_sc = 0;
          m_fc = 0;
        end else begin
          if (st && m_sc < 65535) m_sc++;
          if (fl && m_fc < 65535) m_fc++;
        end
        if (m_hold > 0) m_hold--;
        else if (need > 0) m_hold = need - 1;
      end
    end
  end

  task automatic idle();
    Rs = 0; Rt = 0; UsesRt = 0; Br = 0; Tk = 0;
    ExRd = 0; ExWr = 0; ExDst = 0;
    MemRd = 0; MemDst = 0; Clr = 0;
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  initial begin
    idle();
    Rst = 0;
    nxt();
    chk_en = 1'b1;
    smp();
    chk("rst_pc", PCWrite, 0);
    chk("rst_bubble", IDEX_Bubble, 1);
    chk("rst_stall_cnt", Stall_Cnt, 0);
    chk("rst_hold", State_Hold, 0);

    nxt(); Rst = 1; smp();
    chk("idle_pc", PCWrite, 1);

    // Load-use on Rs.
    nxt(); ExRd = 1; ExDst = 8; Rs = 8; smp();
    chk("lu_pc", PCWrite, 0);
    chk("lu_bubble", IDEX_Bubble, 1);
    nxt(); idle(); smp();
    chk("lu_cnt", Stall_Cnt, 1);
    chk("lu_pc_after", PCWrite, 1);

    // Rt only matters when the instruction reads it.
    nxt(); ExRd = 1; ExDst = 5; Rt = 5; UsesRt = 0; smp();
    chk("rt_unused_pc", PCWrite, 1);
    nxt(); UsesRt = 1; smp();
    chk("rt_used_pc", PCWrite, 0);

    // Register 0 never matches.
    nxt(); idle(); ExRd = 1; ExDst = 0; Rs = 0; smp();
    chk("r0_pc", PCWrite, 1);

    // Branch on a load result: two stall cycles.
    nxt(); idle(); Br = 1; Tk = 1;
    ExRd = 1; ExDst = 9; Rt = 9; smp();
    chk("bl1_pc", PCWrite, 0);
    chk("bl1_flush", IFID_Flush, 0);
    chk("bl1_hold", State_Hold, 0);
    nxt(); idle(); Br = 1; Tk = 1; smp();
    chk("bl2_hold", State_Hold, 1);
    chk("bl2_pc", PCWrite, 0);
    chk("bl2_flush", IFID_Flush, 0);
    nxt(); smp();
    chk("bl3_hold", State_Hold, 0);
    chk("bl3_flush", IFID_Flush, 1);
    chk("bl3_pc", PCWrite, 1);
    nxt(); idle(); smp();
    chk("flush_cnt", Flush_Cnt, 1);
    chk("stall_cnt_4", Stall_Cnt, 4);

    // Branch on an ALU result in EX: one cycle.
    nxt(); Br = 1; ExWr = 1; ExDst = 3; Rs = 3; smp();
    chk("balu_pc", PCWrite, 0);
    nxt(); idle(); smp();
    chk("balu_hold", State_Hold, 0);
    chk("balu_pc_after", PCWrite, 1);

    // Branch on a load in MEM: one cycle.
    nxt(); Br = 1; MemRd = 1; MemDst = 4; Rt = 4; smp();
    chk("bmem_pc", PCWrite, 0);

    // Load-use together with branch-load: longest wins.
    nxt(); idle(); Br = 1; ExRd = 1; ExDst = 6; Rs = 6; smp();
    chk("comb_pc", PCWrite, 0);
    nxt(); idle(); smp();
    chk("comb_hold", State_Hold, 1);
    nxt(); smp();
    chk("comb_run", State_Hold, 0);

    // Clear beats a concurrent stall increment.
    nxt(); Clr = 1; ExRd = 1; ExDst = 8; Rs = 8; smp();
    chk("pre_clr_cnt", Stall_Cnt, 8);
    nxt(); idle(); smp();
    chk("clr_stall", Stall_Cnt, 0);
    chk("clr_flush", Flush_Cnt, 0);

    // Reset while in HOLD abandons the remaining stall.
    nxt(); Br = 1; ExRd = 1; ExDst = 9; Rt = 9; smp();
    nxt(); idle(); Rst = 0; smp();
    chk("rh_pc", PCWrite, 0);
    chk("rh_bubble", IDEX_Bubble, 1);
    nxt(); Rst = 1; smp();
    chk("rh_hold", State_Hold, 0);
    chk("rh_pc_after", PCWrite, 1);
    chk("rh_cnt", Stall_Cnt, 0);

    // Saturation after 65540 stall cycles.
    nxt(); ExRd = 1; ExDst = 8; Rs = 8;
    repeat (65539) nxt();
    nxt(); idle(); smp();
    chk("sat_cnt", Stall_Cnt, 16'hFFFF);
    nxt(); Clr = 1; smp();
    nxt(); Clr = 0; smp();
    chk("sat_clr", Stall_Cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports Clk (in, 1, the only clock) and Rst (in, 1); reset is synchronous and active-low.
REQ-002 SHALL have IFID_RegisterRs, IFID_RegisterRt (in, 5 each): source registers of the instruction in ID.
REQ-003 SHALL have IFID_UsesRt (in, 1): ID instruction reads Rt; 0 for I-type ALU and lw.
REQ-004 SHALL have ID_Branch and ID_BranchTaken (in, 1 each): branch in ID, and its comparison result.
REQ-005 SHALL have IDEX_MemRead, IDEX_RegWrite (in, 1 each) and IDEX_RegDst (in, 5): EX-stage producer.
REQ-006 SHALL have EXMEM_MemRead (in, 1) and EXMEM_RegDst (in, 5): MEM-stage producer.
REQ-007 SHALL have Cnt_Clear (in, 1): synchronous clear of both counters.
REQ-008 SHALL have outputs PCWrite, IFIDWrite, IDEX_Bubble and IFID_Flush (1 each): pipeline control.
REQ-009 SHALL have outputs Stall_Cnt and Flush_Cnt (16 each): saturating performance counters.
REQ-010 SHALL have output State_Hold (1): FSM is in HOLD.

Function
REQ-011 Register 0 SHALL never match any producer; a match requires RegDst != 0.
REQ-012 Load-use: IDEX_MemRead and RegDst matching Rs, or Rt when IFID_UsesRt=1, SHALL raise a 1-cycle stall.
REQ-013 Branch-ALU: ID_Branch, IDEX_RegWrite, IDEX_MemRead=0 and IDEX_RegDst matching Rs or Rt SHALL raise a 1-cycle stall.
REQ-014 Branch-load: ID_Branch, IDEX_MemRead and IDEX_RegDst matching Rs or Rt SHALL raise a 2-cycle stall.
REQ-015 Branch-load-MEM: ID_Branch, EXMEM_MemRead and EXMEM_RegDst matching Rs or Rt SHALL raise a 1-cycle stall.
REQ-016 FSM SHALL have two states, RUN and HOLD.
REQ-017 In RUN, the branch-load condition SHALL move the FSM to HOLD on the next edge; every other condition SHALL leave it in RUN.
REQ-018 HOLD SHALL force a stall for one cycle regardless of inputs and then return to RUN, where conditions are re-evaluated.
REQ-019 Stall cycle (any REQ-012..015 hit in RUN, or any cycle in HOLD): PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0.
REQ-020 Non-stall cycle: PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, IFID_Flush=ID_Branch AND ID_BranchTaken.
REQ-021 Stall SHALL take priority over flush; ID_BranchTaken SHALL be ignored while stalling.
REQ-022 Control outputs SHALL be combinational from state and inputs, giving zero-cycle latency.
REQ-023 Stall_Cnt SHALL increment on each stall cycle and Flush_Cnt on each flush cycle; both SHALL saturate at 16'hFFFF.
REQ-024 Cnt_Clear SHALL zero both counters and take priority over an increment in the same cycle.
REQ-025 Simultaneous load-use and branch conditions SHALL resolve to the longest stall that applies.

Reset
REQ-026 While Rst=0 at a Clk edge: state to RUN, Stall_Cnt and Flush_Cnt to 0, State_Hold to 0.
REQ-027 While Rst=0: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0.
REQ-028 Reset asserted in HOLD SHALL abandon the remaining stall; the first cycle after reset starts in RUN.

Structure
REQ-029 FSM state encodings and the counter width constant SHALL live in the shared pipeline package.
REQ-030 The counter SHALL be one sub-module, sat_counter (16-bit, enable/clear), instantiated twice.
REQ-031 Register-match logic SHALL be combinational inside hazard_unit; all state SHALL be clocked on posedge Clk.

Verification
REQ-032 Load-use: IDEX_MemRead=1, IDEX_RegDst=8, IFID_RegisterRs=8 -> one cycle with PCWrite=0, Bubble=1; Stall_Cnt=1.
REQ-033 Branch-load: ID_Branch=1, IDEX_MemRead=1, IDEX_RegDst=9, IFID_RegisterRt=9 -> stall 2 cycles, State_Hold=1 in cycle 2, then RUN.
REQ-034 Register 0: IDEX_MemRead=1, IDEX_RegDst=0, Rs=0 -> no stall, PCWrite=1.
REQ-035 Taken branch with no hazard -> IFID_Flush=1 for 1 cycle, Flush_Cnt=1; the same branch during a stall -> IFID_Flush=0.
REQ-036 Rst=0 applied in HOLD -> next cycle RUN, counters 0; 65540 forced stalls -> Stall_Cnt=16'hFFFF; Cnt_Clear -> 0.
